instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_if.sv | 19 +
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side port of the unified instruction/data memory.
// The fetch unit is the master; the memory returns the word combinationally.
interface instruction_fetch_unit_if;
   logic        instruction_memory_en;
   logic [31:0] instruction_memory_a;
   logic [31:0] instruction_memory_v;

   modport master (
      output instruction_memory_en,
      output instruction_memory_a,
      input  instruction_memory_v
   );

   modport slave (
      input  instruction_memory_en,
      input  instruction_memory_a,
      output instruction_memory_v
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: walks the PC through memory into a small prefetch FIFO for decode,
// handles branch redirects, and drops the memory enable on halt or fetch fault.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] ADDR_MAX   = 32'h0000_FFFC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                            Clk,
   input  logic                            Reset,
   instruction_fetch_unit_if.master        imem,
   input  logic                            stall,
   input  logic                            branch_taken,
   input  logic [31:0]                     branch_target,
   input  logic                            halt,
   output logic                            inst_valid,
   output logic [31:0]                     inst_out,
   output logic [31:0]                     inst_pc,
   output logic                            fetch_fault
);

   typedef enum logic [1:0] {
      S_RUN,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [2:0] CNT_DEPTH = 3'(FIFO_DEPTH);
   localparam logic [1:0] LAST_PTR  = 2'(FIFO_DEPTH - 1);

   state_t      state;
   logic [31:0] pc;
   logic        en_q;
   logic        fault_q;
   logic [2:0]  count;
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   // Storage is sized for the largest legal depth; only FIFO_DEPTH slots are used.
   logic [31:0] fifo_ins [4];
   logic [31:0] fifo_pc  [4];
   logic [31:0] last_ins;
   logic [31:0] last_pc;
   logic        pop;
   logic        push;

   function automatic logic [1:0] nxt_ptr(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   assign imem.instruction_memory_a  = pc;
   assign imem.instruction_memory_en = en_q;
   assign fetch_fault                = fault_q;

   // When the FIFO is empty the head outputs replay whatever was shown last cycle.
   always_comb begin
      inst_valid = (count != 3'd0);
      pop        = inst_valid & ~stall;
      push       = (count < CNT_DEPTH) | pop;
      inst_out   = inst_valid ? fifo_ins[rd_ptr] : last_ins;
      inst_pc    = inst_valid ? fifo_pc[rd_ptr]  : last_pc;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= S_RUN;
         pc       <= RESET_PC;
         en_q     <= 1'b1;
         fault_q  <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         last_ins <= '0;
         last_pc  <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            fifo_ins[i] <= '0;
            fifo_pc[i]  <= '0;
         end
      end else begin
         last_ins <= inst_out;
         last_pc  <= inst_pc;
         case (state)
            S_RUN: begin
               if (halt) begin
                  state  <= S_HALT;
                  en_q   <= 1'b0;
                  count  <= '0;
                  rd_ptr <= '0;
                  wr_ptr <= '0;
               end else if (branch_taken) begin
                  count  <= '0;
                  rd_ptr <= '0;
                  wr_ptr <= '0;
                  pc     <= branch_target;
                  if (branch_target[1:0] != 2'b00) begin
                     state   <= S_FAULT;
                     fault_q <= 1'b1;
                     en_q    <= 1'b0;
                  end
               end else if (push && (pc > ADDR_MAX)) begin
                  // PC already stepped past the last word; freeze it there.
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
                  en_q    <= 1'b0;
                  count   <= '0;
                  rd_ptr  <= '0;
                  wr_ptr  <= '0;
               end else begin
                  if (push) begin
                     fifo_ins[wr_ptr] <= imem.instruction_memory_v;
                     fifo_pc[wr_ptr]  <= pc;
                     wr_ptr           <= nxt_ptr(wr_ptr);
                     pc               <= pc + 32'd4;
                  end
                  if (pop) begin
                     rd_ptr <= nxt_ptr(rd_ptr);
                  end
                  if (push && !pop) begin
                     count <= count + 3'd1;
                  end
               end
            end
            default: begin
               // HALT and FAULT are terminal until Reset.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed test of instruction_fetch_unit against a behavioural 64 KB memory.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halt;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   int checks;
   int failures;

   logic [31:0] mem [16384];

   instruction_fetch_unit_if imem ();

   assign imem.instruction_memory_v = mem[imem.instruction_memory_a[15:2]];

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .ADDR_MAX   (32'h0000_FFFC),
      .FIFO_DEPTH (2)
   ) dut (
      .Clk           (clk),
      .Reset         (reset),
      .imem          (imem),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt          (halt),
      .inst_valid    (inst_valid),
      .inst_out      (inst_out),
      .inst_pc       (inst_pc),
      .fetch_fault   (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      for (int i = 0; i < 16384; i++) mem[i] = 32'hC000_0000 | (i << 2);
      mem[0]       = 32'h1111_1111;
      mem[1]       = 32'h2222_2222;
      mem[2]       = 32'h3333_3333;
      mem[16]      = 32'h4040_4040;
      mem[16382]   = 32'hFFFF_FFFF;
      mem[16383]   = 32'h0BAD_F00D;
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      halt          = 1'b0;

      // Reset state
      step(); step();
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_out", inst_out, 32'd0);
      check("rst_pc", inst_pc, 32'd0);
      check("rst_fault", {31'd0, fetch_fault}, 32'd0);
      check("rst_en", {31'd0, imem.instruction_memory_en}, 32'd1);
      check("rst_addr", imem.instruction_memory_a, 32'd0);

      // Streaming fetch, one instruction per cycle
      reset = 1'b0;
      step();
      check("s0_valid", {31'd0, inst_valid}, 32'd1);
      check("s0_pc", inst_pc, 32'h0);
      check("s0_out", inst_out, 32'h1111_1111);
      check("s0_addr", imem.instruction_memory_a, 32'h4);
      step();
      check("s1_pc", inst_pc, 32'h4);
      check("s1_out", inst_out, 32'h2222_2222);
      step();
      check("s2_pc", inst_pc, 32'h8);
      check("s2_out", inst_out, 32'h3333_3333);
      check("s2_addr", imem.instruction_memory_a, 32'hC);

      // Stall from first valid: FIFO fills, PC holds at 0x8
      reset = 1'b1;
      step();
      reset = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stl_valid", {31'd0, inst_valid}, 32'd1);
         check("stl_out", inst_out, 32'h1111_1111);
      end
      check("stl_addr", imem.instruction_memory_a, 32'h8);
      stall = 1'b0;
      step();
      check("rel0_pc", inst_pc, 32'h4);
      step();
      check("rel1_pc", inst_pc, 32'h8);
      step();
      check("rel2_pc", inst_pc, 32'hC);
      check("rel2_out", inst_out, 32'hC000_000C);

      // Branch with two entries (0xC, 0x10) buffered
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      step();
      branch_taken  = 1'b0;
      stall         = 1'b0;
      check("br_valid", {31'd0, inst_valid}, 32'd0);
      check("br_hold_pc", inst_pc, 32'hC);
      check("br_addr", imem.instruction_memory_a, 32'h40);
      step();
      check("br_t_valid", {31'd0, inst_valid}, 32'd1);
      check("br_t_pc", inst_pc, 32'h40);
      check("br_t_out", inst_out, 32'h4040_4040);
      step();
      check("br_t1_pc", inst_pc, 32'h44);

      // Misaligned branch target
      branch_taken  = 1'b1;
      branch_target = 32'h42;
      step();
      branch_taken  = 1'b0;
      check("mis_fault", {31'd0, fetch_fault}, 32'd1);
      check("mis_en", {31'd0, imem.instruction_memory_en}, 32'd0);
      check("mis_valid", {31'd0, inst_valid}, 32'd0);
      step();
      check("mis_valid2", {31'd0, inst_valid}, 32'd0);
      check("mis_fault2", {31'd0, fetch_fault}, 32'd1);
      reset = 1'b1;
      step();
      check("clr_fault", {31'd0, fetch_fault}, 32'd0);
      check("clr_en", {31'd0, imem.instruction_memory_en}, 32'd1);

      // Run off the top of memory
      reset         = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'hFFF8;
      step();
      branch_taken  = 1'b0;
      check("top_br_valid", {31'd0, inst_valid}, 32'd0);
      step();
      check("top0_pc", inst_pc, 32'hFFF8);
      check("top0_out", inst_out, 32'hFFFF_FFFF);
      step();
      check("top1_pc", inst_pc, 32'hFFFC);
      check("top1_out", inst_out, 32'h0BAD_F00D);
      check("top1_fault", {31'd0, fetch_fault}, 32'd0);
      step();
      check("top_fault", {31'd0, fetch_fault}, 32'd1);
      check("top_en", {31'd0, imem.instruction_memory_en}, 32'd0);
      check("top_valid", {31'd0, inst_valid}, 32'd0);

      // Halt wins over a simultaneous branch
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      halt          = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      step();
      halt          = 1'b0;
      branch_taken  = 1'b0;
      check("hlt_en", {31'd0, imem.instruction_memory_en}, 32'd0);
      check("hlt_valid", {31'd0, inst_valid}, 32'd0);
      check("hlt_fault", {31'd0, fetch_fault}, 32'd0);
      check("hlt_addr", imem.instruction_memory_a, 32'h4);
      step();
      check("hlt_en2", {31'd0, imem.instruction_memory_en}, 32'd0);
      check("hlt_addr2", imem.instruction_memory_a, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
